// File: rtl/vdp_pkg.sv
// Shared constants for the VDP CPU I/O controller: access codes and
// prefetch FSM state encoding.
package vdp_pkg;

    localparam logic [1:0] CODE_VRAM_RD = 2'd0;
    localparam logic [1:0] CODE_VRAM_WR = 2'd1;
    localparam logic [1:0] CODE_REG_WR  = 2'd2;
    localparam logic [1:0] CODE_CRAM_WR = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2
    } pf_state_t;

endpackage

// File: rtl/vdp_io_ctrl.sv
// VDP CPU port controller: two-byte control latch, VRAM/CRAM/register writes
// and VRAM read prefetch. Define VDP_GG_CRAM_EN for 12-bit two-write palette entries.
module vdp_io_ctrl
    import vdp_pkg::*;
#(
    parameter int VRAM_AW = 14,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               port_wr,
    input  logic               port_rd,
    input  logic               port_sel,
    input  logic [7:0]         port_di,
    output logic [7:0]         port_do,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_di,
    output logic               vram_we,
    input  logic [7:0]         vram_do,
    output logic [4:0]         cram_addr,
    output logic [11:0]        cram_di,
    output logic               cram_we,
    output logic [3:0]         reg_addr,
    output logic [7:0]         reg_di,
    output logic               reg_we,
    input  logic [7:0]         status_in,
    output logic               status_rd,
    output logic               busy,
    output logic               drop
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    pf_state_t          state, state_nxt;
    logic [1:0]         wait_cnt;
    logic               capture;
    logic               flag;
    logic [7:0]         low;
    logic [1:0]         code;
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         rbuf;
    logic               inc_pend;

    logic strobe, both, accept;
    logic data_wr, ctrl_wr, data_rd, ctrl_rd, start_pf;

    assign vram_addr = addr;
    assign busy      = (state != IDLE);

    assign strobe  = port_wr | port_rd;
    assign both    = port_wr & port_rd;
    assign accept  = strobe & ~both & ~busy;
    assign data_wr = accept & port_wr & ~port_sel;
    assign ctrl_wr = accept & port_wr &  port_sel;
    assign data_rd = accept & port_rd & ~port_sel;
    assign ctrl_rd = accept & port_rd &  port_sel;
    assign start_pf = data_rd | (ctrl_wr & flag & (port_di[7:6] == CODE_VRAM_RD));

    // A write issued last cycle has not yet bumped addr; palette indexing
    // must see the address it will land on.
`ifdef VDP_GG_CRAM_EN
    logic [5:0] cram_idx;
    logic [7:0] cram_lat;
    assign cram_idx = addr[5:0] + 6'(inc_pend);
`else
    logic [4:0] cram_idx;
    assign cram_idx = addr[4:0] + 5'(inc_pend);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == RD_ISSUE)
                wait_cnt <= 2'd0;
            else if (state == RD_WAIT)
                wait_cnt <= wait_cnt + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:     if (start_pf) state_nxt = RD_ISSUE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag      <= 1'b0;
            low       <= '0;
            code      <= '0;
            addr      <= '0;
            rbuf      <= '0;
            inc_pend  <= 1'b0;
            drop      <= 1'b0;
            port_do   <= '0;
            vram_di   <= '0;
            vram_we   <= 1'b0;
            cram_addr <= '0;
            cram_di   <= '0;
            cram_we   <= 1'b0;
            reg_addr  <= '0;
            reg_di    <= '0;
            reg_we    <= 1'b0;
            status_rd <= 1'b0;
`ifdef VDP_GG_CRAM_EN
            cram_lat  <= '0;
`endif
        end else begin
            vram_we   <= 1'b0;
            cram_we   <= 1'b0;
            reg_we    <= 1'b0;
            status_rd <= 1'b0;
            inc_pend  <= 1'b0;

            if (inc_pend || capture)
                addr <= addr + 1'b1;
            if (capture)
                rbuf <= vram_do;
            if (strobe && (busy || both))
                drop <= 1'b1;

            if (ctrl_wr) begin
                if (!flag) begin
                    low  <= port_di;
                    flag <= 1'b1;
                end else begin
                    code <= port_di[7:6];
                    addr <= VRAM_AW'({port_di[5:0], low});
                    flag <= 1'b0;
                    if (port_di[7:6] == CODE_REG_WR) begin
                        reg_we   <= 1'b1;
                        reg_addr <= port_di[3:0];
                        reg_di   <= low;
                    end
                end
            end

            if (data_wr) begin
                flag     <= 1'b0;
                rbuf     <= port_di;
                inc_pend <= 1'b1;
                if (code == CODE_CRAM_WR) begin
`ifdef VDP_GG_CRAM_EN
                    if (!cram_idx[0]) begin
                        cram_lat <= port_di;
                    end else begin
                        cram_we   <= 1'b1;
                        cram_addr <= cram_idx[5:1];
                        cram_di   <= {port_di[3:0], cram_lat};
                    end
`else
                    cram_we   <= 1'b1;
                    cram_addr <= cram_idx;
                    cram_di   <= {6'b0, port_di[5:0]};
`endif
                end else begin
                    vram_we <= 1'b1;
                    vram_di <= port_di;
                end
            end

            if (data_rd) begin
                flag    <= 1'b0;
                port_do <= rbuf;
            end

            if (ctrl_rd) begin
                flag      <= 1'b0;
                port_do   <= status_in;
                status_rd <= 1'b1;
                drop      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdp_io_ctrl.sv
// Directed bench for vdp_io_ctrl with a synchronous VRAM model (RD_LAT=1).
module tb_vdp_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        port_wr, port_rd, port_sel;
    logic [7:0]  port_di, port_do;
    logic [13:0] vram_addr;
    logic [7:0]  vram_di, vram_do;
    logic        vram_we;
    logic [4:0]  cram_addr;
    logic [11:0] cram_di;
    logic        cram_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_di;
    logic        reg_we;
    logic [7:0]  status_in;
    logic        status_rd, busy, drop;

    int checks   = 0;
    int failures = 0;
    int busy_cnt;

    logic [7:0] mem [0:16383];

    always #5 clk = ~clk;

    vdp_io_ctrl #(.VRAM_AW(14), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .port_wr(port_wr), .port_rd(port_rd), .port_sel(port_sel),
        .port_di(port_di), .port_do(port_do),
        .vram_addr(vram_addr), .vram_di(vram_di), .vram_we(vram_we), .vram_do(vram_do),
        .cram_addr(cram_addr), .cram_di(cram_di), .cram_we(cram_we),
        .reg_addr(reg_addr), .reg_di(reg_di), .reg_we(reg_we),
        .status_in(status_in), .status_rd(status_rd),
        .busy(busy), .drop(drop)
    );

    // VRAM: one-cycle synchronous read
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_di;
        vram_do <= mem[vram_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; strobe is seen by the next posedge, returns at the following negedge.
    task automatic strobe(input logic wr, input logic rd, input logic sel, input logic [7:0] d);
        port_wr = wr; port_rd = rd; port_sel = sel; port_di = d;
        @(negedge clk);
        port_wr = 1'b0; port_rd = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk(tag, 16'(busy), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        rst_n = 1'b0; port_wr = 0; port_rd = 0; port_sel = 0; port_di = 0; status_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_port_do", 16'(port_do), 16'h0);
        chk("rst_vram_addr", 16'(vram_addr), 16'h0);
        chk("rst_strobes", {11'b0, vram_we, cram_we, reg_we, status_rd, 1'b0}, 16'h0);
        chk("rst_busy_drop", {14'b0, busy, drop}, 16'h0);
        chk("rst_cram_reg", {cram_di[3:0], reg_di, reg_addr}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // VRAM write at 0x1234
        strobe(1, 0, 1, 8'h34);
        strobe(1, 0, 1, 8'h52);
        chk("ctl_addr", 16'(vram_addr), 16'h1234);
        chk("ctl_no_busy", 16'(busy), 16'h0);
        strobe(1, 0, 0, 8'hAB);
        chk("wr_we", 16'(vram_we), 16'h1);
        chk("wr_addr", 16'(vram_addr), 16'h1234);
        chk("wr_di", 16'(vram_di), 16'h00AB);
        @(negedge clk);
        chk("wr_we_off", 16'(vram_we), 16'h0);
        chk("wr_addr_inc", 16'(vram_addr), 16'h1235);
        chk("wr_mem", 16'(mem[14'h1234]), 16'h00AB);

        // Register write
        strobe(1, 0, 1, 8'h07);
        strobe(1, 0, 1, 8'h81);
        chk("reg_we", 16'(reg_we), 16'h1);
        chk("reg_addr", 16'(reg_addr), 16'h1);
        chk("reg_di", 16'(reg_di), 16'h07);
        chk("reg_no_mem", {14'b0, vram_we, cram_we}, 16'h0);
        @(negedge clk);
        chk("reg_we_off", 16'(reg_we), 16'h0);
        chk("reg_addr_reg", 16'(vram_addr), 16'h0107);

        // Read prefetch
        strobe(1, 0, 1, 8'h00);
        strobe(1, 0, 1, 8'h00);
        chk("pf_busy", 16'(busy), 16'h1);
        wait_idle("pf_idle0");
        chk("pf_addr1", 16'(vram_addr), 16'h1);
        strobe(0, 1, 0, 8'h00);
        chk("rd0_data", 16'(port_do), 16'h11);
        busy_cnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk("rd0_busy_len", 16'(busy_cnt), 16'd2);
        chk("rd0_addr", 16'(vram_addr), 16'h2);
        strobe(0, 1, 0, 8'h00);
        chk("rd1_data", 16'(port_do), 16'h22);
        chk("rd1_busy", 16'(busy), 16'h1);

        // Strobe while busy is dropped
        strobe(0, 1, 0, 8'h00);
        chk("drop_set", 16'(drop), 16'h1);
        chk("drop_do_kept", 16'(port_do), 16'h22);
        wait_idle("drop_idle");
        chk("drop_no_extra_pf", 16'(vram_addr), 16'h3);
        status_in = 8'h5A;
        strobe(0, 1, 1, 8'h00);
        chk("stat_do", 16'(port_do), 16'h5A);
        chk("stat_rd", 16'(status_rd), 16'h1);
        chk("stat_drop_clr", 16'(drop), 16'h0);
        @(negedge clk);
        chk("stat_rd_off", 16'(status_rd), 16'h0);

        // Simultaneous wr+rd
        strobe(1, 1, 0, 8'h99);
        chk("both_drop", 16'(drop), 16'h1);
        chk("both_no_effect", {8'b0, port_do}, 16'h5A);
        chk("both_no_we_busy", {14'b0, vram_we, busy}, 16'h0);
        strobe(0, 1, 1, 8'h00);
        chk("both_drop_clr", 16'(drop), 16'h0);

        // Address wrap
        strobe(1, 0, 1, 8'hFF);
        strobe(1, 0, 1, 8'h7F);
        chk("wrap_addr", 16'(vram_addr), 16'h3FFF);
        strobe(1, 0, 0, 8'h3C);
        chk("wrap_we", 16'(vram_we), 16'h1);
        chk("wrap_we_addr", 16'(vram_addr), 16'h3FFF);
        @(negedge clk);
        chk("wrap_zero", 16'(vram_addr), 16'h0000);
        chk("wrap_mem", 16'(mem[14'h3FFF]), 16'h3C);

        // Palette writes
        strobe(1, 0, 1, 8'h00);
        strobe(1, 0, 1, 8'hC0);
        chk("cram_no_pf", 16'(busy), 16'h0);
        strobe(1, 0, 0, 8'hEE);
        chk("cram_no_vram", 16'(vram_we), 16'h0);
`ifdef VDP_GG_CRAM_EN
        chk("gg_even_no_we", 16'(cram_we), 16'h0);
        @(negedge clk);
        strobe(1, 0, 0, 8'h0F);
        chk("gg_we", 16'(cram_we), 16'h1);
        chk("gg_addr", 16'(cram_addr), 16'h0);
        chk("gg_di", 16'(cram_di), 16'h0FEE);
`else
        chk("cram_we0", 16'(cram_we), 16'h1);
        chk("cram_addr0", 16'(cram_addr), 16'h0);
        chk("cram_di0", 16'(cram_di), 16'h002E);
        @(negedge clk);
        strobe(1, 0, 0, 8'h0F);
        chk("cram_we1", 16'(cram_we), 16'h1);
        chk("cram_addr1", 16'(cram_addr), 16'h1);
        chk("cram_di1", 16'(cram_di), 16'h000F);
`endif
        @(negedge clk);
        chk("cram_we_off", 16'(cram_we), 16'h0);
        chk("cram_addr_inc", 16'(vram_addr), 16'h2);

        // Reset mid-prefetch
        strobe(1, 0, 1, 8'h00);
        strobe(1, 0, 1, 8'h00);
        chk("rstpf_busy", 16'(busy), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("rstpf_async", {13'b0, busy, drop, port_do[0]}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstpf_addr", 16'(vram_addr), 16'h0);
        chk("rstpf_idle", 16'(busy), 16'h0);
        strobe(0, 1, 0, 8'h00);
        chk("rstpf_rbuf", 16'(port_do), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
